// File: rtl/clock_pkg.sv
// Shared definitions for the clock project: mode and arbiter state encodings
// and a constant clog2 helper used to size counters.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_STOPWATCH = 2'd1,
    MODE_TIMER     = 2'd2,
    MODE_SENSOR    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GUARD = 2'd1,
    ST_ALERT = 2'd2
  } arb_state_e;

  // Number of bits needed to hold values 0..v-1 (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mode_arbiter.sv
// Mode arbiter: selects the active controller, routes shared buttons and the
// Set switch, blanks routing after mode changes, and preempts into Timer mode
// with a buzzer when the timer expires, restoring the prior mode afterwards.
module mode_arbiter
  import clock_pkg::*;
#(
  parameter int P_GUARD_CYC = 100_000,
  parameter int P_BEEP_CYC  = 25_000_000
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iBtn_U,
  input  logic       iBtn_D,
  input  logic       iBtn_L,
  input  logic       iBtn_R,
  input  logic       iBtn_C,
  input  logic       iSet,
  input  logic       iTimer_End,
  output logic [1:0] oMode,
  output logic       oClock,
  output logic       oStopwatch,
  output logic       oTimer,
  output logic       oSensor,
  output logic       oBtn_U,
  output logic       oBtn_D,
  output logic       oBtn_L,
  output logic       oBtn_R,
  output logic       oSet,
  output logic       oAlert,
  output logic       oBuzz
);

  // One counter serves both the guard window and the beep half-period.
  localparam int CNT_MAX = (P_GUARD_CYC > P_BEEP_CYC) ? P_GUARD_CYC : P_BEEP_CYC;
  localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(P_GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] BEEP_LAST  = CNT_W'(P_BEEP_CYC - 1);

  arb_state_e       state_reg, state_next;
  mode_e            mode_reg, mode_next;
  mode_e            saved_reg, saved_next;
  logic             end_d_reg;
  logic             buzz_reg, buzz_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rise;

  assign rise = iTimer_End & ~end_d_reg;

  // State, mode, counter and buzzer registers with asynchronous reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_reg <= ST_RUN;
      mode_reg  <= MODE_CLOCK;
      saved_reg <= MODE_CLOCK;
      end_d_reg <= 1'b0;
      buzz_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      saved_reg <= saved_next;
      end_d_reg <= iTimer_End;
      buzz_reg  <= buzz_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; a timer-end rising edge overrides everything outside ALERT.
  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    saved_next = saved_reg;
    cnt_next   = cnt_reg;
    buzz_next  = 1'b0;

    case (state_reg)
      ST_RUN: begin
        cnt_next = '0;
        if (iBtn_C && !iSet) begin
          mode_next  = mode_e'(mode_reg + 2'd1);
          state_next = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (cnt_reg == GUARD_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_ALERT: begin
        if (!iTimer_End) begin
          mode_next  = saved_reg;
          state_next = ST_GUARD;
          cnt_next   = '0;
        end else if (cnt_reg == BEEP_LAST) begin
          buzz_next = ~buzz_reg;
          cnt_next  = '0;
        end else begin
          buzz_next = buzz_reg;
          cnt_next  = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase

    if (rise && state_reg != ST_ALERT) begin
      state_next = ST_ALERT;
      cnt_next   = '0;
      buzz_next  = 1'b1;
      if (mode_reg != MODE_TIMER) begin
        saved_next = mode_reg;
        mode_next  = MODE_TIMER;
      end else begin
        saved_next = MODE_TIMER;
      end
    end
  end

  // Combinational routing gates, qualified by the registered state.
  logic routing;
  assign routing = iRst_n && (state_reg == ST_RUN);

  assign oBtn_U = iBtn_U & (routing | (iRst_n && state_reg == ST_ALERT));
  assign oBtn_D = iBtn_D & routing;
  assign oBtn_L = iBtn_L & routing;
  assign oBtn_R = iBtn_R & routing;
  assign oSet   = iSet & routing;

  assign oMode      = mode_reg;
  assign oClock     = (mode_reg == MODE_CLOCK);
  assign oStopwatch = (mode_reg == MODE_STOPWATCH);
  assign oTimer     = (mode_reg == MODE_TIMER);
  assign oSensor    = (mode_reg == MODE_SENSOR);
  assign oAlert     = (state_reg == ST_ALERT);
  assign oBuzz      = buzz_reg;

endmodule

// File: tb/tb_mode_arbiter.sv
// Self-checking bench for mode_arbiter: directed scenarios plus randomized
// traffic, compared each cycle against a behavioural model of the arbiter.
module tb_mode_arbiter;

  localparam int G = 4;
  localparam int B = 8;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iBtn_U = 0, iBtn_D = 0, iBtn_L = 0, iBtn_R = 0, iBtn_C = 0;
  logic       iSet = 0, iTimer_End = 0;
  logic [1:0] oMode;
  logic       oClock, oStopwatch, oTimer, oSensor;
  logic       oBtn_U, oBtn_D, oBtn_L, oBtn_R, oSet, oAlert, oBuzz;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  int m_mode, m_saved, m_guard_left, m_alert_cycles;
  bit m_alert, m_end_prev;

  mode_arbiter #(.P_GUARD_CYC(G), .P_BEEP_CYC(B)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iBtn_U(iBtn_U), .iBtn_D(iBtn_D), .iBtn_L(iBtn_L), .iBtn_R(iBtn_R),
    .iBtn_C(iBtn_C), .iSet(iSet), .iTimer_End(iTimer_End),
    .oMode(oMode), .oClock(oClock), .oStopwatch(oStopwatch), .oTimer(oTimer),
    .oSensor(oSensor), .oBtn_U(oBtn_U), .oBtn_D(oBtn_D), .oBtn_L(oBtn_L),
    .oBtn_R(oBtn_R), .oSet(oSet), .oAlert(oAlert), .oBuzz(oBuzz)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_saved = 0; m_guard_left = 0; m_alert_cycles = 0;
    m_alert = 0; m_end_prev = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model, then advance the model across the coming rising edge.
  task automatic cyc(input logic c, u, d, l, r, s, e);
    bit routing, rise, exp_buzz;
    logic [3:0] exp_btn;
    @(negedge iClk);
    iBtn_C = c; iBtn_U = u; iBtn_D = d; iBtn_L = l; iBtn_R = r;
    iSet = s; iTimer_End = e;
    #1;
    routing  = !m_alert && (m_guard_left == 0);
    exp_btn  = {u & (routing | m_alert), d & routing, l & routing, r & routing};
    exp_buzz = m_alert && (((m_alert_cycles / B) % 2) == 0);
    check("mode", {6'd0, oMode}, 8'(m_mode));
    check("onehot", {4'd0, oSensor, oTimer, oStopwatch, oClock}, 8'(1 << m_mode));
    check("btn", {4'd0, oBtn_U, oBtn_D, oBtn_L, oBtn_R}, {4'd0, exp_btn});
    check("set", {7'd0, oSet}, {7'd0, s & routing});
    check("alert", {7'd0, oAlert}, {7'd0, m_alert});
    check("buzz", {7'd0, oBuzz}, {7'd0, exp_buzz});
    rise = e && !m_end_prev;
    if (!m_alert && rise) begin
      m_alert = 1; m_alert_cycles = 0; m_guard_left = 0;
      if (m_mode != 2) m_saved = m_mode;
      else m_saved = 2;
      m_mode = 2;
    end else if (m_alert) begin
      if (!e) begin
        m_mode = m_saved; m_alert = 0; m_guard_left = G;
      end else begin
        m_alert_cycles++;
      end
    end else if (m_guard_left > 0) begin
      m_guard_left--;
    end else if (c && !s) begin
      m_mode = (m_mode + 1) % 4; m_guard_left = G;
    end
    m_end_prev = e;
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, e);
  endtask

  initial begin
    bit set_lvl, end_lvl;
    int hold;
    model_reset();
    #12;
    check("rst_mode", {6'd0, oMode}, 8'd0);
    check("rst_en", {4'd0, oSensor, oTimer, oStopwatch, oClock}, 8'h01);
    check("rst_out", {2'd0, oBtn_U, oBtn_D, oBtn_L, oBtn_R, oSet, oAlert}, 8'h00);
    check("rst_buzz", {7'd0, oBuzz}, 8'd0);
    @(negedge iClk);
    iRst_n = 1'b1;

    // Scenario: four mode advances, 10 cycles apart.
    $display("[TB] scenario mode stepping");
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("plan_step", {6'd0, oMode}, 8'((k + 1) % 4));
      idle(8, 0);
    end

    // Scenario: guard blanking after a mode change.
    $display("[TB] scenario guard blanking");
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("plan_same_cyc_u", {7'd0, oBtn_U}, 8'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      check("plan_guard_u", {7'd0, oBtn_U}, (i == 5) ? 8'd1 : 8'd0);
    end

    // Scenario: mode change refused while Set is on.
    $display("[TB] scenario set lockout");
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("plan_set_mode", {6'd0, oMode}, 8'd1);
    check("plan_set_pass", {7'd0, oSet}, 8'd1);
    idle(2, 0);

    // Scenario: alert from Sensor mode, restore to Sensor.
    $display("[TB] scenario alert from sensor");
    cyc(1, 0, 0, 0, 0, 0, 0); idle(6, 0);
    cyc(1, 0, 0, 0, 0, 0, 0); idle(6, 0);
    check("plan_mode3", {6'd0, oMode}, 8'd3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("plan_alert_mode", {6'd0, oMode}, 8'd2);
    check("plan_alert_buzz", {6'd0, oAlert, oBuzz}, 8'd3);
    for (int i = 0; i < 20; i++) cyc(0, i[0], 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("plan_restore", {6'd0, oMode}, 8'd3);
    idle(6, 0);

    // Scenario: Centre press and timer rise together from Clock mode.
    $display("[TB] scenario simultaneous centre and alert");
    cyc(1, 0, 0, 0, 0, 0, 0); idle(6, 0);
    check("plan_mode0", {6'd0, oMode}, 8'd0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("plan_sim_mode", {6'd0, oMode}, 8'd2);
    idle(5, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("plan_sim_restore", {6'd0, oMode}, 8'd0);
    idle(6, 0);

    // Scenario: asynchronous reset in the middle of an alert.
    $display("[TB] scenario reset mid-alert");
    cyc(1, 0, 0, 0, 0, 0, 0); idle(6, 0);
    cyc(0, 0, 0, 0, 0, 0, 1); idle(5, 1);
    check("plan_pre_rst", {6'd0, oMode}, 8'd2);
    #3;
    iTimer_End = 0;
    iRst_n = 1'b0;
    #1;
    check("arst_mode", {6'd0, oMode}, 8'd0);
    check("arst_en", {4'd0, oSensor, oTimer, oStopwatch, oClock}, 8'h01);
    check("arst_alert", {6'd0, oAlert, oBuzz}, 8'd0);
    model_reset();
    @(negedge iClk);
    iRst_n = 1'b1;
    idle(3, 0);

    // Randomized traffic against the model.
    $display("[TB] scenario random traffic");
    set_lvl = 0; end_lvl = 0; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) set_lvl = ~set_lvl;
      if (hold > 0) hold--;
      else if (end_lvl) begin
        end_lvl = 0; hold = $urandom_range(30, 3);
      end else if ($urandom_range(39) == 0) begin
        end_lvl = 1; hold = $urandom_range(40, 1);
      end
      cyc($urandom_range(5) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
          $urandom_range(3) == 0, $urandom_range(3) == 0, set_lvl, end_lvl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
